// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the BCD stopwatch.
// FSM state encoding and the packed display word layout.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam logic [3:0] UNIT_MAX    = 4'd9;
  localparam logic [3:0] TENS_MAX    = 4'd5;
  localparam logic [3:0] HR_TENS_MAX = 4'd2;
  localparam logic [3:0] HR_UNIT_TOP = 4'd3;

  typedef struct packed {
    logic [3:0] hr_1;
    logic [3:0] hr_0;
    logic [3:0] min_1;
    logic [3:0] min_0;
    logic [3:0] sec_1;
    logic [3:0] sec_0;
    logic [3:0] cent_1;
    logic [3:0] cent_0;
  } sw_time_t;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..MAX; carry is combinational
// so a whole digit chain advances in a single cycle.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = UNIT_MAX
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] digit,
  output logic       carry
);

  assign carry = inc && (digit == MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit <= '0;
    end else if (clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= (digit == MAX) ? 4'd0 : digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd.sv
// HH:MM:SS.cc BCD stopwatch with start/stop/clear controls.
// Define STOPWATCH_LAP_EN to build the lap display freeze.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [3:0] cent_0,
  output logic [3:0] cent_1,
  output logic [3:0] sec_0,
  output logic [3:0] sec_1,
  output logic [3:0] min_0,
  output logic [3:0] min_1,
  output logic [3:0] hr_0,
  output logic [3:0] hr_1,
  output logic       running,
  output logic       wrap
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);

  sw_state_t state_q, state_d;

  logic armed;
  logic start_q, stop_q, clear_q;
  logic start_e, stop_e, clear_e;

  logic [PW-1:0] presc_q;
  logic          tick;

  logic c_cent0, c_cent1, c_sec0, c_sec1;
  logic c_min0, c_min1, c_hr0;
  logic hr_carry_unused;
  logic hr_wrap;

  sw_time_t live, disp;

  // armed keeps levels held across reset release from firing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed   <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      clear_q <= 1'b0;
      start_e <= 1'b0;
      stop_e  <= 1'b0;
      clear_e <= 1'b0;
    end else begin
      armed   <= 1'b1;
      start_q <= start;
      stop_q  <= stop;
      clear_q <= clear;
      start_e <= armed & start & ~start_q;
      stop_e  <= armed & stop & ~stop_q;
      clear_e <= armed & clear & ~clear_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    priority case (1'b1)
      clear_e:
        state_d = IDLE;
      stop_e && (state_q == RUN):
        state_d = PAUSE;
      start_e && (state_q != RUN):
        state_d = RUN;
      default: ;
    endcase
  end

  always_comb begin
    running = (state_q == RUN);
  end

  assign tick = running && (presc_q == PRE_TOP);

  // PAUSE holds the partial period so resume continues it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
    end else if (clear_e || state_q == IDLE) begin
      presc_q <= '0;
    end else if (state_q == RUN) begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
    end
  end

  assign hr_wrap = c_min1
                && (live.hr_1 == HR_TENS_MAX)
                && (live.hr_0 == HR_UNIT_TOP);

  bcd_digit_cnt #(.MAX(UNIT_MAX)) u_cent0 (
    .clk(clk), .rst(rst),
    .inc(tick), .clr(clear_e),
    .digit(live.cent_0), .carry(c_cent0)
  );

  bcd_digit_cnt #(.MAX(UNIT_MAX)) u_cent1 (
    .clk(clk), .rst(rst),
    .inc(c_cent0), .clr(clear_e),
    .digit(live.cent_1), .carry(c_cent1)
  );

  bcd_digit_cnt #(.MAX(UNIT_MAX)) u_sec0 (
    .clk(clk), .rst(rst),
    .inc(c_cent1), .clr(clear_e),
    .digit(live.sec_0), .carry(c_sec0)
  );

  bcd_digit_cnt #(.MAX(TENS_MAX)) u_sec1 (
    .clk(clk), .rst(rst),
    .inc(c_sec0), .clr(clear_e),
    .digit(live.sec_1), .carry(c_sec1)
  );

  bcd_digit_cnt #(.MAX(UNIT_MAX)) u_min0 (
    .clk(clk), .rst(rst),
    .inc(c_sec1), .clr(clear_e),
    .digit(live.min_0), .carry(c_min0)
  );

  bcd_digit_cnt #(.MAX(TENS_MAX)) u_min1 (
    .clk(clk), .rst(rst),
    .inc(c_min0), .clr(clear_e),
    .digit(live.min_1), .carry(c_min1)
  );

  bcd_digit_cnt #(.MAX(UNIT_MAX)) u_hr0 (
    .clk(clk), .rst(rst),
    .inc(c_min1), .clr(clear_e | hr_wrap),
    .digit(live.hr_0), .carry(c_hr0)
  );

  bcd_digit_cnt #(.MAX(HR_TENS_MAX)) u_hr1 (
    .clk(clk), .rst(rst),
    .inc(c_hr0), .clr(clear_e | hr_wrap),
    .digit(live.hr_1), .carry(hr_carry_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap <= 1'b0;
    end else begin
      wrap <= hr_wrap & ~clear_e;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic     lap_q, lap_e;
  logic     freeze_q;
  sw_time_t snap_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_q <= 1'b0;
      lap_e <= 1'b0;
    end else begin
      lap_q <= lap;
      lap_e <= armed & lap & ~lap_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      freeze_q <= 1'b0;
      snap_q   <= '0;
    end else if (clear_e) begin
      freeze_q <= 1'b0;
    end else if (lap_e && state_q != IDLE) begin
      freeze_q <= ~freeze_q;
      if (!freeze_q) begin
        snap_q <= live;
      end
    end
  end

  assign disp = freeze_q ? snap_q : live;
`else
  logic lap_unused;

  assign lap_unused = lap;
  assign disp       = live;
`endif

  assign cent_0 = disp.cent_0;
  assign cent_1 = disp.cent_1;
  assign sec_0  = disp.sec_0;
  assign sec_1  = disp.sec_1;
  assign min_0  = disp.min_0;
  assign min_1  = disp.min_1;
  assign hr_0   = disp.hr_0;
  assign hr_1   = disp.hr_1;

endmodule

// File: doc/stopwatch_bcd.md
STOPWATCH_BCD -- requirements
Module: stopwatch_bcd

Interface
REQ-001 SHALL have parameter TICK_DIV, default 1000000, meaning clk cycles per centisecond tick (100 MHz -> 100 Hz), legal range >= 2.
REQ-002 SHALL have port clk  input  1  system clock, all state rising-edge.
REQ-003 SHALL have port rst  input  1  reset: one clock; asynchronous, active-low.
REQ-004 SHALL have port start  input  1  level, rising edge starts/resumes counting.
REQ-005 SHALL have port stop  input  1  level, rising edge pauses counting.
REQ-006 SHALL have port clear  input  1  level, rising edge zeroes time and returns to IDLE.
REQ-007 SHALL have port lap  input  1  level, rising edge toggles display freeze (REQ-024).
REQ-008 SHALL have ports cent_0, cent_1, sec_0, sec_1, min_0, min_1, hr_0, hr_1  output  4 each  BCD digits, _0 units, _1 tens; these feed the display mapper directly.
REQ-009 SHALL have port running  output  1  high in RUN state.
REQ-010 SHALL have port wrap  output  1  one-cycle pulse on 23:59:59.99 -> 00:00:00.00 rollover.

Function
REQ-011 SHALL register start/stop/clear/lap and act on rising edges only; an edge sampled at edge n takes effect at edge n+1.
REQ-012 SHALL implement FSM IDLE, RUN, PAUSE: IDLE-start->RUN; RUN-stop->PAUSE; PAUSE-start->RUN; any-clear->IDLE.
REQ-013 SHALL give priority clear > stop > start when edges coincide; start in RUN and stop in IDLE/PAUSE are ignored.
REQ-014 SHALL run a prescaler 0..TICK_DIV-1 only in RUN; on reaching TICK_DIV-1 it returns to 0 and issues one tick.
REQ-015 SHALL hold the prescaler value in PAUSE (resume continues the partial period) and zero it in IDLE.
REQ-016 SHALL increment the time on the same edge the prescaler wraps; first cent_0=1 occurs TICK_DIV edges after entering RUN.
REQ-017 SHALL count cent 00-99, sec 00-59, min 00-59, hr 00-23, each digit carrying to the next in the same cycle.
REQ-018 SHALL on 23:59:59.99 + tick set all digits 0 and assert wrap for exactly one cycle; counting continues.
REQ-019 SHALL never output a non-BCD digit (>9) or tens digits above 5 (sec, min) / 2 (hr).
REQ-020 SHALL let clear coincident with a tick win: digits 0, wrap low.

Reset
REQ-021 SHALL on rst low immediately force IDLE, prescaler 0, all digits 0, running 0, wrap 0, edge registers 0, freeze off.
REQ-022 SHALL, mid-RUN reset, discard the partial period; after release, require a fresh start edge.
REQ-023 SHALL treat inputs held high across reset release as not edges (edge registers reset to 0 capture the level on the first edge without firing... 0->1 seen as edge is NOT allowed: edge registers load the input level during reset release cycle before detection enables).

Configuration
REQ-024 SHALL with STOPWATCH_LAP_EN defined: lap edge in RUN or PAUSE toggles freeze; while frozen, digit outputs show the snapshot taken at the freezing edge while internal counting continues; clear or reset releases freeze; lap in IDLE ignored.
REQ-025 SHALL without STOPWATCH_LAP_EN: lap port present but ignored, outputs always show live count, no snapshot registers synthesised.

Structure
REQ-026 SHALL place FSM state typedef (IDLE/RUN/PAUSE) and digit limit constants (9, 5, 2, 3) in shared package stopwatch_pkg.
REQ-027 SHALL use one sub-module bcd_digit_cnt (parameter MAX; inputs inc, clr; outputs digit, carry), instantiated per digit; hour limit 23 handled by combined hr_1/hr_0 wrap logic in the top.

Verification (TICK_DIV=4)
REQ-028 SHALL cover: rst low then high, start pulse -> running=1 next cycle, cent_0=1 after 4 RUN cycles, cent=10 after 40.
REQ-029 SHALL cover: preload-by-run to 00:00:59.99, one tick -> 00:01:00.00, wrap=0.
REQ-030 SHALL cover: reach 23:59:59.99, one tick -> 00:00:00.00, wrap high exactly one cycle, running stays 1.
REQ-031 SHALL cover: stop after 2 prescaler cycles, wait 20, start -> next increment after 2 further RUN cycles, digits unchanged during PAUSE.
REQ-032 SHALL cover: start, stop, clear edges in same cycle -> IDLE, all digits 0; clear on tick cycle -> digits 0.
REQ-033 SHALL cover (STOPWATCH_LAP_EN): lap at 00:00:00.05 -> outputs hold 05 for 40 cycles, second lap -> outputs show 00:00:00.15.
